// File: rtl/lcd_bus_pkg.sv
// Shared definitions for the LCD bus arbiter: FSM state type and size limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lcd_bus_pkg;

  // Arbiter FSM: IDLE has no bus owner, OWN has exactly one granted channel.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Word width: bit DW-1 is the LCD D/C flag, the low bits are pixel/command data.
  localparam int DW_DEFAULT = 9;

  // Largest supported number of requesting channels.
  localparam int N_CH_MAX = 8;

endpackage

// File: rtl/lcd_bus_arb_if.sv
// Bundle of request-side and output-side signals of the LCD bus arbiter.
// Latency: n/a (wiring only).
// Backpressure: req_ready per channel, q_ready from downstream.
// Ports: req_valid/req_data/req_last/req_ready per channel, q_valid/q_data/q_last/q_ready
// for the merged output stream, grant (one-hot owner) and busy status.
interface lcd_bus_arb_if
  import lcd_bus_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DW   = DW_DEFAULT
) ();

  logic [N_CH-1:0]         req_valid;
  logic [N_CH-1:0][DW-1:0] req_data;
  logic [N_CH-1:0]         req_last;
  logic [N_CH-1:0]         req_ready;
  logic                    q_valid;
  logic [DW-1:0]           q_data;
  logic                    q_last;
  logic                    q_ready;
  logic [N_CH-1:0]         grant;
  logic                    busy;

  // Driver of the channels and consumer of the output stream.
  modport master (
    output req_valid, req_data, req_last, q_ready,
    input  req_ready, q_valid, q_data, q_last, grant, busy
  );

  // The arbiter itself.
  modport slave (
    input  req_valid, req_data, req_last, q_ready,
    output req_ready, q_valid, q_data, q_last, grant, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping at N_CH.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; pick is all zero when no request is present.
// Ports: req (request vector), ptr (search start index), pick (one-hot winner).
module rr_arbiter #(
  parameter int N_CH = 2,
  parameter int PW   = 1
) (
  input  logic [N_CH-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [N_CH-1:0] pick
);

  logic [2*N_CH-1:0] req_dbl;
  logic [N_CH-1:0]   rot;
  logic [N_CH-1:0]   rot_pick;
  logic [2*N_CH-1:0] pick_dbl;
  logic              found;

  // Rotate so that channel ptr lands on bit 0, then a fixed priority scan
  // from bit 0 gives the round-robin order.
  assign req_dbl = {req, req};
  assign rot     = req_dbl[ptr +: N_CH];

  always_comb begin
    rot_pick = '0;
    found    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        rot_pick[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Undo the rotation; a bit pushed past the top wraps back to the bottom half.
  assign pick_dbl = {{N_CH{1'b0}}, rot_pick} << ptr;
  assign pick     = pick_dbl[N_CH-1:0] | pick_dbl[2*N_CH-1:N_CH];

endmodule

// File: rtl/lcd_bus_arb.sv
// Round-robin arbiter merging N_CH burst sources onto one registered LCD word stream.
// Latency: 2 cycles from request in IDLE to q_valid; then 1 word/clock within a burst.
// Backpressure: q_ready low holds the output register and drops the owner's req_ready.
// Ports: clk, reset (async, active high), bus (slave side of lcd_bus_arb_if).
module lcd_bus_arb
  import lcd_bus_pkg::*;
#(
  parameter int N_CH = 2,
  parameter int DW   = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  lcd_bus_arb_if.slave  bus
);

  localparam int PW = (N_CH > 1) ? $clog2(N_CH) : 1;

  state_t          state;
  logic [N_CH-1:0] grant_q;
  logic [PW-1:0]   ptr;        // first channel to examine at the next arbitration
  logic [N_CH-1:0] pick;

  logic            q_valid_q;
  logic [DW-1:0]   q_data_q;
  logic            q_last_q;

  logic            can_xfer;
  logic [N_CH-1:0] ready;
  logic            xfer;
  logic [DW-1:0]   xfer_data;
  logic            xfer_last;
  logic [PW-1:0]   owner_idx;
  logic [PW-1:0]   ptr_nxt;

  rr_arbiter #(
    .N_CH (N_CH),
    .PW   (PW)
  ) u_rr (
    .req  (bus.req_valid),
    .ptr  (ptr),
    .pick (pick)
  );

  // The owner may move a word whenever the output register is empty or draining.
  assign can_xfer = (state == OWN) && (!q_valid_q || bus.q_ready);
  assign ready    = can_xfer ? grant_q : '0;
  assign xfer     = |(ready & bus.req_valid);

  // grant_q is one-hot in OWN, so OR-ing the granted lanes is a plain mux.
  always_comb begin
    xfer_data = '0;
    xfer_last = 1'b0;
    owner_idx = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant_q[i]) begin
        xfer_data = xfer_data | bus.req_data[i];
        xfer_last = xfer_last | bus.req_last[i];
        owner_idx = PW'(i);
      end
    end
  end

  // Next search starts just after the channel that finished its burst.
  assign ptr_nxt = (owner_idx == PW'(N_CH - 1)) ? '0 : owner_idx + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant_q <= '0;
      ptr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state   <= OWN;
            grant_q <= pick;
          end
        end
        OWN: begin
          // Bus is released on the edge that moves the last word; the
          // output register drains independently of the FSM.
          if (xfer && xfer_last) begin
            state   <= IDLE;
            grant_q <= '0;
            ptr     <= ptr_nxt;
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_valid_q <= 1'b0;
      q_data_q  <= '0;
      q_last_q  <= 1'b0;
    end else if (xfer) begin
      q_valid_q <= 1'b1;
      q_data_q  <= xfer_data;
      q_last_q  <= xfer_last;
    end else if (bus.q_ready) begin
      q_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready;
  assign bus.q_valid   = q_valid_q;
  assign bus.q_data    = q_data_q;
  assign bus.q_last    = q_last_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_lcd_bus_arb.sv
// Bench for lcd_bus_arb: a 2-channel and a 4-channel instance against a burst-level model.
// Latency: n/a.
// Backpressure: q_ready driven per instance, directed or random.
module tb_lcd_bus_arb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lcd_bus_arb_if #(.N_CH(2), .DW(9)) if0 ();
  lcd_bus_arb_if #(.N_CH(4), .DW(9)) if1 ();

  lcd_bus_arb #(.N_CH(2), .DW(9)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  lcd_bus_arb #(.N_CH(4), .DW(9)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  // Per-channel source queues, entry = {last, data}; index d*8+c.
  logic [9:0] chq [16][$];
  bit         en [2][8];
  bit         qr [2];
  bit         rnd;

  logic [7:0] rv [2];
  logic [8:0] rd [2][8];
  logic       rl [2][8];

  // Model: current owner (-1 when idle), next search start, output register.
  int         owner [2];
  int         start [2];
  bit         mqv [2];
  logic [8:0] mqd [2];
  bit         mql [2];

  logic [7:0] prev_g [2];
  logic [7:0] glog [2][$];
  logic [9:0] olog [2][$];

  int vectors = 0;
  int miscompares = 0;

  function automatic int nch(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  task automatic read_dut(input int d, output logic [7:0] g, output logic [7:0] rr,
                          output logic b, output logic v, output logic [8:0] dat,
                          output logic l);
    if (d == 0) begin
      g = 8'(if0.grant); rr = 8'(if0.req_ready); b = if0.busy;
      v = if0.q_valid;   dat = if0.q_data;        l = if0.q_last;
    end else begin
      g = 8'(if1.grant); rr = 8'(if1.req_ready); b = if1.busy;
      v = if1.q_valid;   dat = if1.q_data;        l = if1.q_last;
    end
  endtask

  task automatic clear_logs();
    for (int d = 0; d < 2; d++) begin
      glog[d].delete();
      olog[d].delete();
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      owner[d] = -1; start[d] = 0;
      mqv[d] = 1'b0; mqd[d] = '0; mql[d] = 1'b0;
      prev_g[d] = '0;
      for (int c = 0; c < 8; c++) en[d][c] = 1'b1;
      qr[d] = 1'b1;
    end
    for (int k = 0; k < 16; k++) chq[k].delete();
  endtask

  task automatic drive_zero();
    if0.req_valid = '0; if0.req_data = '0; if0.req_last = '0; if0.q_ready = 1'b1;
    if1.req_valid = '0; if1.req_data = '0; if1.req_last = '0; if1.q_ready = 1'b1;
  endtask

  task automatic check_model(input int d);
    logic [7:0] g, rr, eg, er;
    logic b, v, l;
    logic [8:0] dat;
    bit can;
    read_dut(d, g, rr, b, v, dat, l);
    eg = '0;
    if (owner[d] >= 0) eg[owner[d]] = 1'b1;
    can = (owner[d] >= 0) && (!mqv[d] || qr[d]);
    er = can ? eg : 8'h00;
    chk($sformatf("d%0d grant", d), g, eg);
    chk($sformatf("d%0d req_ready", d), rr, er);
    chk($sformatf("d%0d busy", d), b, (owner[d] >= 0));
    chk($sformatf("d%0d q_valid", d), v, mqv[d]);
    chk($sformatf("d%0d q_data", d), dat, mqd[d]);
    chk($sformatf("d%0d q_last", d), l, mql[d]);
    if (g != 0 && prev_g[d] == 0) glog[d].push_back(g);
    prev_g[d] = g;
    if (v && qr[d]) olog[d].push_back({l, dat});
  endtask

  task automatic model_step(input int d);
    int o, n, c;
    bit found;
    n = nch(d);
    o = owner[d];
    if (o < 0) begin
      found = 1'b0;
      for (int i = 0; i < n; i++) begin
        c = (start[d] + i) % n;
        if (!found && rv[d][c]) begin
          owner[d] = c;
          found = 1'b1;
        end
      end
      if (mqv[d] && qr[d]) mqv[d] = 1'b0;
    end else if ((!mqv[d] || qr[d]) && rv[d][o]) begin
      mqv[d] = 1'b1;
      mqd[d] = rd[d][o];
      mql[d] = rl[d][o];
      void'(chq[d*8+o].pop_front());
      if (rl[d][o]) begin
        start[d] = (o + 1) % n;
        owner[d] = -1;
      end
    end else if (mqv[d] && qr[d]) begin
      mqv[d] = 1'b0;
    end
  endtask

  task automatic gen_random();
    int len;
    for (int d = 0; d < 2; d++) begin
      qr[d] = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < nch(d); c++) begin
        en[d][c] = ($urandom_range(0, 7) != 0);
        if (chq[d*8+c].size() == 0 && $urandom_range(0, 3) == 0) begin
          len = $urandom_range(1, 4);
          for (int w = 0; w < len; w++)
            chq[d*8+c].push_back({(w == len - 1), 9'($urandom_range(0, 511))});
        end
      end
    end
  endtask

  // One clock: drive at the falling edge, check 1 time unit later, advance the model.
  task automatic cycle();
    int k;
    if (rnd) gen_random();
    for (int d = 0; d < 2; d++) begin
      rv[d] = '0;
      for (int c = 0; c < 8; c++) begin
        k = d * 8 + c;
        rd[d][c] = '0;
        rl[d][c] = 1'b0;
        if (c < nch(d) && chq[k].size() > 0) begin
          rv[d][c] = en[d][c];
          rd[d][c] = chq[k][0][8:0];
          rl[d][c] = chq[k][0][9];
        end
      end
    end
    if0.req_valid = rv[0][1:0];
    if1.req_valid = rv[1][3:0];
    for (int c = 0; c < 2; c++) begin
      if0.req_data[c] = rd[0][c];
      if0.req_last[c] = rl[0][c];
    end
    for (int c = 0; c < 4; c++) begin
      if1.req_data[c] = rd[1][c];
      if1.req_last[c] = rl[1][c];
    end
    if0.q_ready = qr[0];
    if1.q_ready = qr[1];
    #1;
    for (int d = 0; d < 2; d++) begin
      check_model(d);
      model_step(d);
    end
    @(negedge clk);
  endtask

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int k = 0; k < 16; k++) if (chq[k].size() != 0) r = 1'b0;
    for (int d = 0; d < 2; d++) if (owner[d] >= 0 || mqv[d]) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string nm);
    for (int d = 0; d < 2; d++) begin
      qr[d] = 1'b1;
      for (int c = 0; c < 8; c++) en[d][c] = 1'b1;
    end
    for (int i = 0; i < 300 && !all_idle(); i++) cycle();
    cycle();
    vectors++;
    if (!all_idle()) begin
      miscompares++;
      $display("FAIL %s drain: stream still busy after 300 cycles", nm);
    end
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic apply_reset();
    logic [7:0] g, rr;
    logic b, v, l;
    logic [8:0] dat;
    #2 reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      read_dut(d, g, rr, b, v, dat, l);
      chk($sformatf("rst d%0d grant", d), g, 0);
      chk($sformatf("rst d%0d req_ready", d), rr, 0);
      chk($sformatf("rst d%0d busy", d), b, 0);
      chk($sformatf("rst d%0d q_valid", d), v, 0);
      chk($sformatf("rst d%0d q_data", d), dat, 0);
      chk($sformatf("rst d%0d q_last", d), l, 0);
    end
    model_reset();
    drive_zero();
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] gl(input int d, input int i);
    return (glog[d].size() > i) ? 16'(glog[d][i]) : 16'hffff;
  endfunction

  function automatic logic [15:0] ol(input int d, input int i);
    return (olog[d].size() > i) ? 16'(olog[d][i]) : 16'hffff;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rnd = 1'b0;
    reset = 1'b1;
    model_reset();
    drive_zero();
    @(negedge clk);
    apply_reset();

    // Single word on ch0: visible two clocks after request, FSM already idle.
    clear_logs();
    chq[0].push_back({1'b1, 9'h020});
    cycle();
    cycle();
    chk("single q_valid", if0.q_valid, 1);
    chk("single q_data", if0.q_data, 9'h020);
    chk("single q_last", if0.q_last, 1);
    chk("single busy", if0.busy, 0);
    drain("single");

    // Simultaneous one-word bursts after reset: ch0 first, then ch1.
    apply_reset();
    clear_logs();
    chq[0].push_back({1'b1, 9'h0AA});
    chq[1].push_back({1'b1, 9'h1BB});
    drain("simul");
    chk("simul grant0", gl(0, 0), 8'h01);
    chk("simul grant1", gl(0, 1), 8'h02);
    chk("simul word0", ol(0, 0), 10'h2AA);
    chk("simul word1", ol(0, 1), 10'h3BB);

    // ch1 burst of three with the sink stalled for four clocks.
    clear_logs();
    chq[1].push_back({1'b0, 9'h101});
    chq[1].push_back({1'b0, 9'h102});
    chq[1].push_back({1'b1, 9'h103});
    qr[0] = 1'b0;
    repeat (4) cycle();
    chk("bp q_valid", if0.q_valid, 1);
    chk("bp q_data", if0.q_data, 9'h101);
    chk("bp req_ready", 8'(if0.req_ready), 8'h00);
    drain("bp");
    chk("bp count", olog[0].size(), 3);
    chk("bp word0", ol(0, 0), 10'h101);
    chk("bp word1", ol(0, 1), 10'h102);
    chk("bp word2", ol(0, 2), 10'h303);

    // Both channels requesting back-to-back single words: strict alternation.
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      chq[0].push_back({1'b1, 9'(8'h30 + i)});
      chq[1].push_back({1'b1, 9'(8'h40 + i)});
    end
    drain("fair");
    chk("fair g0", gl(0, 0), 8'h01);
    chk("fair g1", gl(0, 1), 8'h02);
    chk("fair g2", gl(0, 2), 8'h01);
    chk("fair g3", gl(0, 3), 8'h02);

    // Leave the pointer on ch1, then reset in the middle of a ch0 burst.
    chq[0].push_back({1'b1, 9'h055});
    drain("pre-rst");
    clear_logs();
    for (int i = 0; i < 4; i++) chq[0].push_back({(i == 3), 9'(8'h11 + i)});
    repeat (3) cycle();
    chk("mid q_data", if0.q_data, 9'h012);
    apply_reset();
    clear_logs();
    chq[0].push_back({1'b1, 9'h066});
    chq[1].push_back({1'b1, 9'h077});
    drain("post-rst");
    chk("post-rst g0", gl(0, 0), 8'h01);
    chk("post-rst word0", ol(0, 0), 10'h266);

    // Four-channel instance, only ch3 requesting.
    clear_logs();
    chq[8+3].push_back({1'b1, 9'h0FF});
    cycle();
    chk("n4 grant", 8'(if1.grant), 8'h08);
    drain("n4");
    chk("n4 word", ol(1, 0), 10'h2FF);

    // Random bursts, stalls and backpressure on both instances.
    rnd = 1'b1;
    repeat (1500) cycle();
    rnd = 1'b0;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
